ps2_ascii_kbd: RTL and testbench

Upstream keyboard stage of the typing game. It receives PS/2 scan-code set 2 frames from the keyboard pins, checks each frame, and tracks make/break/extended prefixes and the shift keys. It produces the held-key ASCII byte (`kbdata`) that the video/game memory stage samples; that value is 0 whenever no mapped key is held. It also exports the raw scancode, a new-key strobe and a key counter for HEX display and debug.

---
 rtl/ps2_ascii_kbd.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_ascii_kbd.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_kbd.sv
// PS/2 set-2 keyboard front end: frame receiver, make/break/extended decoder,
// shift tracking and ASCII mapping of the currently held key.
module ps2_ascii_kbd #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbdata,
  output logic [7:0] scancode,
  output logic       key_down,
  output logic       ready,
  output logic       frame_err,
  output logic [7:0] key_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {R_IDLE, R_RECV} rx_state_t;
  typedef enum logic [1:0] {NORM, BRK, EXT, EXT_BRK} dec_state_t;

  logic [2:0] clk_sync_reg, dat_sync_reg;
  logic       clk_prev_reg;
  logic [1:0] fill_reg;
  logic       armed_reg;
  logic       fall;

  // Edges are only honoured once the synchronizer has refilled from the pin
  // and the line has been seen high, so a low ps2_clk at reset cannot start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg <= 3'b111;
      dat_sync_reg <= 3'b111;
      clk_prev_reg <= 1'b1;
      fill_reg     <= 2'd0;
      armed_reg    <= 1'b0;
    end else begin
      clk_sync_reg <= {clk_sync_reg[1:0], ps2_clk};
      dat_sync_reg <= {dat_sync_reg[1:0], ps2_data};
      clk_prev_reg <= clk_sync_reg[2];
      if (fill_reg != 2'd3) fill_reg <= fill_reg + 2'd1;
      else if (clk_sync_reg[2]) armed_reg <= 1'b1;
    end
  end

  assign fall = armed_reg & clk_prev_reg & ~clk_sync_reg[2];

  rx_state_t      rx_state_reg, rx_state_next;
  logic [3:0]     bit_cnt_reg, bit_cnt_next;
  logic [10:0]    shift_reg, shift_next;
  logic [CW-1:0]  idle_reg, idle_next;
  logic           byte_valid_reg, byte_valid_next;
  logic           frame_err_reg, frame_err_next;
  logic [7:0]     rx_byte_reg, rx_byte_next;
  logic [10:0]    frame;

  assign frame = {dat_sync_reg[2], shift_reg[10:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg   <= R_IDLE;
      bit_cnt_reg    <= 4'd0;
      shift_reg      <= 11'd0;
      idle_reg       <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      rx_byte_reg    <= 8'd0;
    end else begin
      rx_state_reg   <= rx_state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      idle_reg       <= idle_next;
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
      rx_byte_reg    <= rx_byte_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    idle_next       = idle_reg;
    byte_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    rx_byte_next    = rx_byte_reg;
    case (rx_state_reg)
      R_IDLE: begin
        if (fall) begin
          shift_next    = frame;
          bit_cnt_next  = 4'd1;
          idle_next     = '0;
          rx_state_next = R_RECV;
        end
      end
      default: begin
        if (fall) begin
          shift_next = frame;
          idle_next  = '0;
          if (bit_cnt_reg == 4'd10) begin
            rx_state_next = R_IDLE;
            bit_cnt_next  = 4'd0;
            // start low, stop high, odd parity over data plus parity bit
            if (!frame[0] && frame[10] && (^frame[9:1])) begin
              byte_valid_next = 1'b1;
              rx_byte_next    = frame[8:1];
            end else begin
              frame_err_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else if (idle_reg >= CW'(TIMEOUT)) begin
          rx_state_next = R_IDLE;
          bit_cnt_next  = 4'd0;
        end else begin
          idle_next = idle_reg + CW'(1);
        end
      end
    endcase
  end

  function automatic logic [7:0] map_key(input logic [7:0] b, input logic shift);
    logic [7:0] up;
    logic [7:0] other;
    up    = 8'h00;
    other = 8'h00;
    case (b)
      8'h1C: up = 8'h41;  8'h32: up = 8'h42;  8'h21: up = 8'h43;  8'h23: up = 8'h44;
      8'h24: up = 8'h45;  8'h2B: up = 8'h46;  8'h34: up = 8'h47;  8'h33: up = 8'h48;
      8'h43: up = 8'h49;  8'h3B: up = 8'h4A;  8'h42: up = 8'h4B;  8'h4B: up = 8'h4C;
      8'h3A: up = 8'h4D;  8'h31: up = 8'h4E;  8'h44: up = 8'h4F;  8'h4D: up = 8'h50;
      8'h15: up = 8'h51;  8'h2D: up = 8'h52;  8'h1B: up = 8'h53;  8'h2C: up = 8'h54;
      8'h3C: up = 8'h55;  8'h2A: up = 8'h56;  8'h1D: up = 8'h57;  8'h22: up = 8'h58;
      8'h35: up = 8'h59;  8'h1A: up = 8'h5A;
      8'h45: other = 8'h30;  8'h16: other = 8'h31;  8'h1E: other = 8'h32;
      8'h26: other = 8'h33;  8'h25: other = 8'h34;  8'h2E: other = 8'h35;
      8'h36: other = 8'h36;  8'h3D: other = 8'h37;  8'h3E: other = 8'h38;
      8'h46: other = 8'h39;  8'h29: other = 8'h20;  8'h5A: other = 8'h0D;
      default: ;
    endcase
    if (up != 8'h00) return shift ? up + 8'd32 : up;
    return other;
  endfunction

  dec_state_t dec_state_reg, dec_state_next;
  logic       shift_l_reg, shift_l_next, shift_r_reg, shift_r_next;
  logic [7:0] kbdata_reg, kbdata_next, scancode_reg, scancode_next, key_cnt_reg, key_cnt_next;
  logic       key_down_reg, key_down_next, ready_reg, ready_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state_reg <= NORM;
      shift_l_reg   <= 1'b0;
      shift_r_reg   <= 1'b0;
      kbdata_reg    <= 8'd0;
      scancode_reg  <= 8'd0;
      key_cnt_reg   <= 8'd0;
      key_down_reg  <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      dec_state_reg <= dec_state_next;
      shift_l_reg   <= shift_l_next;
      shift_r_reg   <= shift_r_next;
      kbdata_reg    <= kbdata_next;
      scancode_reg  <= scancode_next;
      key_cnt_reg   <= key_cnt_next;
      key_down_reg  <= key_down_next;
      ready_reg     <= ready_next;
    end
  end

  always_comb begin
    dec_state_next = dec_state_reg;
    shift_l_next   = shift_l_reg;
    shift_r_next   = shift_r_reg;
    kbdata_next    = kbdata_reg;
    scancode_next  = scancode_reg;
    key_cnt_next   = key_cnt_reg;
    key_down_next  = key_down_reg;
    ready_next     = 1'b0;
    if (byte_valid_reg) begin
      case (dec_state_reg)
        NORM: begin
          if (rx_byte_reg == 8'hF0)      dec_state_next = BRK;
          else if (rx_byte_reg == 8'hE0) dec_state_next = EXT;
          else if (rx_byte_reg == 8'h12) shift_l_next = 1'b1;
          else if (rx_byte_reg == 8'h59) shift_r_next = 1'b1;
          else if (!(rx_byte_reg == scancode_reg && key_down_reg)) begin
            scancode_next = rx_byte_reg;
            key_down_next = 1'b1;
            kbdata_next   = map_key(rx_byte_reg, shift_l_reg | shift_r_reg);
            ready_next    = 1'b1;
            key_cnt_next  = key_cnt_reg + 8'd1;
          end
        end
        BRK: begin
          dec_state_next = NORM;
          if (rx_byte_reg == 8'h12)      shift_l_next = 1'b0;
          else if (rx_byte_reg == 8'h59) shift_r_next = 1'b0;
          else if (rx_byte_reg == scancode_reg) begin
            key_down_next = 1'b0;
            kbdata_next   = 8'd0;
          end
        end
        EXT:     dec_state_next = (rx_byte_reg == 8'hF0) ? EXT_BRK : NORM;
        default: dec_state_next = NORM;
      endcase
    end
  end

  assign kbdata    = kbdata_reg;
  assign scancode  = scancode_reg;
  assign key_down  = key_down_reg;
  assign ready     = ready_reg;
  assign frame_err = frame_err_reg;
  assign key_cnt   = key_cnt_reg;

endmodule

// File: tb/tb_ps2_ascii_kbd.sv
// Bench for ps2_ascii_kbd: directed PS/2 frames; each expected make is queued
// and a monitor checks it (including 5-cycle latency) when ready pulses.
module tb_ps2_ascii_kbd;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kbdata, scancode, key_cnt;
  logic       key_down, ready, frame_err;

  ps2_ascii_kbd #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbdata(kbdata), .scancode(scancode), .key_down(key_down),
    .ready(ready), .frame_err(frame_err), .key_cnt(key_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] kb;
    logic [7:0] sc;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         err_seen = 0;
  int         err_exp = 0;
  int         fall_cyc = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per ready pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready) begin
        chk("ready_width", {31'd0, prev_ready}, 0);
        chk("ready_with_err", {31'd0, frame_err}, 0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready actual=1 required=0 scancode=%0h", scancode);
        end else begin
          e = q.pop_front();
          chk("kbdata", {24'd0, kbdata}, {24'd0, e.kb});
          chk("scancode", {24'd0, scancode}, {24'd0, e.sc});
          chk("key_cnt", {24'd0, key_cnt}, {24'd0, e.cnt});
          chk("key_down", {31'd0, key_down}, 1);
          chk("latency", cyc, e.cyc);
          $display("make sc=%h kbdata=%h key_cnt=%0d cyc=%0d", scancode, kbdata, key_cnt, cyc);
        end
      end
      if (frame_err) begin
        err_seen++;
        $display("frame_err at cyc=%0d", cyc);
      end
      prev_ready = ready;
    end
  end

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      fall_cyc = cyc;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic gap();
    repeat (12) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    gap();
  endtask

  task automatic make_key(input logic [7:0] b, input logic [7:0] kb);
    exp_t e;
    send_bits(mk_frame(b, 1'b0), 11);
    exp_cnt = exp_cnt + 8'd1;
    e.kb = kb; e.sc = b; e.cnt = exp_cnt; e.cyc = fall_cyc + 5;
    q.push_back(e);
    gap();
  endtask

  task automatic chk_held(input string nm, input logic [7:0] kb, input logic [7:0] sc,
                          input logic kd, input logic [7:0] cnt);
    chk({nm, "_kbdata"}, {24'd0, kbdata}, {24'd0, kb});
    chk({nm, "_scancode"}, {24'd0, scancode}, {24'd0, sc});
    chk({nm, "_key_down"}, {31'd0, key_down}, {31'd0, kd});
    chk({nm, "_key_cnt"}, {24'd0, key_cnt}, {24'd0, cnt});
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_held("reset", 8'h00, 8'h00, 1'b0, 8'h00);
    chk("reset_ready", {31'd0, ready}, 0);
    chk("reset_frame_err", {31'd0, frame_err}, 0);

    make_key(8'h1C, 8'h41);
    chk_held("make_a", 8'h41, 8'h1C, 1'b1, 8'd1);

    key(8'h1C); key(8'h1C);
    key(8'hF0); key(8'h1C);
    chk_held("break_a", 8'h00, 8'h1C, 1'b0, 8'd1);

    key(8'h12);
    make_key(8'h1C, 8'h61);
    key(8'hF0); key(8'h1C);
    key(8'hF0); key(8'h12);
    make_key(8'h1C, 8'h41);
    chk_held("shift_seq", 8'h41, 8'h1C, 1'b1, 8'd3);

    send_bits(mk_frame(8'h16, 1'b1), 11);
    err_exp++;
    gap();
    chk_held("bad_parity", 8'h41, 8'h1C, 1'b1, 8'd3);

    key(8'hE0); key(8'h75);
    key(8'hE0); key(8'hF0); key(8'h75);
    chk_held("extended", 8'h41, 8'h1C, 1'b1, 8'd3);
    make_key(8'h24, 8'h45);

    key(8'h59);
    make_key(8'h16, 8'h31);
    make_key(8'h1A, 8'h7A);
    key(8'hF0); key(8'h59);
    make_key(8'h5A, 8'h0D);
    make_key(8'h76, 8'h00);

    // Partial frame must be dropped silently by the idle timeout.
    send_bits(mk_frame(8'h29, 1'b0), 4);
    repeat (TMO + 100) @(negedge clk);
    make_key(8'h29, 8'h20);
    chk_held("after_timeout", 8'h20, 8'h29, 1'b1, exp_cnt);

    // Reset mid-frame with ps2_clk held low.
    send_bits(mk_frame(8'h32, 1'b0), 5);
    ps2_clk = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    chk_held("mid_reset", 8'h00, 8'h00, 1'b0, 8'h00);
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    make_key(8'h1C, 8'h41);
    chk_held("post_reset", 8'h41, 8'h1C, 1'b1, 8'd1);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) make_key(8'h1C, 8'h41);
      else            make_key(8'h32, 8'h42);
    end
    chk("wrap_key_cnt", {24'd0, key_cnt}, 0);

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("frame_err_count", err_seen, err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
